// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike interface blocks.
package spike_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
  localparam int ISI_W_DEF = 16;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Control and result bundle between a spike rate decoder and its user.
interface spike_rate_decoder_if
  import spike_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ISI_W = ISI_W_DEF
);

  logic             en;
  logic             spike_in;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] rate;
  logic             rate_sat;
  logic             rate_valid;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;

  modport master (
    output en, spike_in, window_len,
    input  rate, rate_sat, rate_valid, isi, isi_valid
  );

  modport slave (
    input  en, spike_in, window_len,
    output rate, rate_sat, rate_valid, isi, isi_valid
  );

endinterface

// File: rtl/spike_edge_detect.sv
// Rising-edge pulse for a spike line; SPIKE_SYNC_EN adds a 2-flop synchronizer in front.
module spike_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic spike_i,
  output logic edge_o
);

  logic spike_s;
  logic spike_q;

`ifdef SPIKE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], spike_i};
  end

  assign spike_s = sync_q[1];
`else
  assign spike_s = spike_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) spike_q <= 1'b0;
    else     spike_q <= spike_s;
  end

  assign edge_o = spike_s & ~spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a spike line into per-window rate counts and inter-spike intervals.
// Optional input synchronizer is selected by SPIKE_SYNC_EN (see spike_edge_detect).
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ISI_W = ISI_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_rate_decoder_if.slave  bus_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [ISI_W-1:0] timer_q, timer_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_sat_q, rate_sat_d;
  logic             rate_valid_q, rate_valid_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;
  logic             edge_w;

  spike_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .spike_i (bus_if.spike_in),
    .edge_o  (edge_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      count_q      <= '0;
      sat_q        <= 1'b0;
      timer_q      <= '0;
      armed_q      <= 1'b0;
      rate_q       <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      timer_q      <= timer_d;
      armed_q      <= armed_d;
      rate_q       <= rate_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    count_d      = count_q;
    sat_d        = sat_q;
    timer_d      = timer_q;
    armed_d      = armed_q;
    rate_d       = rate_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = 1'b0;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;
    // sat flags an edge that arrived while the count was already full
    cnt_nxt = (edge_w && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;
    sat_nxt = sat_q | (edge_w && (count_q == CNT_MAX));

    case (state_q)
      IDLE: begin
        if (bus_if.en && (bus_if.window_len != '0)) begin
          state_d   = RUN;
          win_cnt_d = bus_if.window_len;
          count_d   = '0;
          sat_d     = 1'b0;
          timer_d   = '0;
          armed_d   = 1'b0;
        end
      end
      RUN: begin
        if (!bus_if.en) begin
          state_d = IDLE;
        end else begin
          if (edge_w) begin
            timer_d = ISI_W'(1);
            armed_d = 1'b1;
            if (armed_q) begin
              isi_d       = timer_q;
              isi_valid_d = 1'b1;
            end
          end else if (timer_q != ISI_MAX) begin
            timer_d = timer_q + ISI_W'(1);
          end

          // an edge in the final cycle still belongs to the closing window
          if (win_cnt_q == WIN_W'(1)) begin
            rate_d       = cnt_nxt;
            rate_sat_d   = sat_nxt;
            rate_valid_d = 1'b1;
            win_cnt_d    = bus_if.window_len;
            count_d      = '0;
            sat_d        = 1'b0;
            if (bus_if.window_len == '0) state_d = IDLE;
          end else begin
            win_cnt_d = win_cnt_q - WIN_W'(1);
            count_d   = cnt_nxt;
            sat_d     = sat_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.rate       = rate_q;
  assign bus_if.rate_sat   = rate_sat_q;
  assign bus_if.rate_valid = rate_valid_q;
  assign bus_if.isi        = isi_q;
  assign bus_if.isi_valid  = isi_valid_q;

endmodule
